// File: rtl/skylark_display_pkg.sv
// Shared types and constants for the seven-segment display scanner.
package skylark_display_pkg;

  localparam int unsigned NUM_DIGITS_DEF = 8;

  typedef logic [2:0] digit_idx_t;
  typedef logic [3:0] nibble_t;

  localparam logic [NUM_DIGITS_DEF-1:0] ANODES_OFF = '1;

endpackage

// File: rtl/display_scanner_if.sv
// Value-update handshake plus encoder/anode outputs of the display scanner.
interface display_scanner_if #(
  parameter int unsigned NUM_DIGITS = 8
);

  logic [4*NUM_DIGITS-1:0] value;
  logic                    value_valid;
  logic                    value_ready;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [3:0]              num;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   anodes;
  logic                    frame_done;

  // Core/bench side: offers values, observes the scan outputs.
  modport master (
    output value, value_valid, dp_mask,
    input  value_ready, num, dp, anodes, frame_done
  );

  // Scanner side.
  modport slave (
    input  value, value_valid, dp_mask,
    output value_ready, num, dp, anodes, frame_done
  );

endinterface

// File: rtl/refresh_timer.sv
// Digit-slot timer: counts 0..REFRESH_DIV-1 and flags the blank phase.
module refresh_timer #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic slot_tick,  // this edge wraps the counter
  output logic blank       // phase of the cycle that follows this edge
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count and phase; blank looks ahead so outputs registered on this edge line up.
  always_comb begin
    slot_tick = (cnt_q == CntW'(REFRESH_DIV - 1));
    cnt_d     = slot_tick ? '0 : cnt_q + CntW'(1);
    blank     = (32'(cnt_d) < BLANK_CYCLES);
  end

  // Slot counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed hex scanner with blanking, leading-zero suppression and
// a tear-free single-entry value update path.
module display_scanner
  import skylark_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          LZ_SUPPRESS  = 1'b1
) (
  input logic clk,
  input logic reset,
  display_scanner_if.slave bus
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  logic slot_tick, blank_nx;

  refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .slot_tick(slot_tick),
    .blank    (blank_nx)
  );

  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d, pend_q, upper;
  logic                    pend_full_q;
  nibble_t                 num_q, num_d;
  logic                    dp_q, dp_d, lit_q, lit_d;
  logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
  logic                    frame_done_q;
  logic                    commit, xfer, lz;

  assign bus.value_ready = ~pend_full_q;
  assign bus.num         = num_q;
  assign bus.dp          = dp_q;
  assign bus.anodes      = anodes_q;
  assign bus.frame_done  = frame_done_q;

  // Next-state for index, display and encoder outputs, all computed for the
  // upcoming cycle so num/anodes change together with the slot counter.
  always_comb begin
    xfer   = bus.value_valid && !pend_full_q;
    commit = slot_tick && (idx_q == LastIdx);

    idx_d = idx_q;
    if (slot_tick) idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);

    display_d = display_q;
    if (commit) begin
      if (pend_full_q) display_d = pend_q;
      else if (xfer)   display_d = bus.value;  // bypass when nothing is queued
    end

    // Digit is a leading zero when it and every higher nibble are zero.
    upper = display_d >> {idx_d, 2'b00};
    lz    = LZ_SUPPRESS && (idx_d != '0) && (upper == '0);

    lit_d = slot_tick ? (!lz || bus.dp_mask[idx_d]) : lit_q;
    num_d = slot_tick ? display_d[{idx_d, 2'b00} +: 4] : num_q;
    dp_d  = slot_tick ? ~bus.dp_mask[idx_d] : dp_q;

    anodes_d = (blank_nx || !lit_d) ? '1 : ~(NUM_DIGITS'(1) << idx_d);
  end

  // Scan, handshake and registered output state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q        <= '0;
      display_q    <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      num_q        <= '0;
      dp_q         <= 1'b1;
      lit_q        <= 1'b1;
      anodes_q     <= '1;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      display_q    <= display_d;
      num_q        <= num_d;
      dp_q         <= dp_d;
      lit_q        <= lit_d;
      anodes_q     <= anodes_d;
      frame_done_q <= commit;
      if (commit && pend_full_q) begin
        pend_full_q <= 1'b0;
      end else if (xfer && !commit) begin
        pend_q      <= bus.value;
        pend_full_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexed scan controller sitting directly upstream of display_encoder.
- Holds a 32-bit value to show (debug/register readout from the core) and steps through its hex digits.
- Presents one nibble plus decimal point per slot on num/dp, which feed the encoder.
- Drives the common-anode enables for an 8-digit seven-segment bank, with anti-ghosting blanking and leading-zero suppression.

Parameters:
- NUM_DIGITS, 8: digits scanned; value width = 4*NUM_DIGITS.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be at least 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.
- LZ_SUPPRESS, 1: 1 = blank leading zero digits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- value  in  4*NUM_DIGITS  value to display.
- value_valid  in  1  value offered this cycle.
- value_ready  out  1  update slot free.
- dp_mask  in  NUM_DIGITS  1 = decimal point lit on that digit. Sampled live, not shadowed.
- num  out  4  nibble for encoder.
- dp  out  1  decimal point to encoder, active-low.
- anodes  out  NUM_DIGITS  digit enables, active-low.
- frame_done  out  1  one-cycle pulse at end of each full scan.

Behaviour:
Reset (asynchronous assert, synchronous release on clk):
- anodes = all 1, num = 0, dp = 1, frame_done = 0, value_ready = 1.
- Slot counter = 0, digit index = 0, display register = 0, pending register empty.

Slot timing:
- Slot counter runs 0..REFRESH_DIV-1 and wraps.
- On wrap, digit index advances 0..NUM_DIGITS-1, then back to 0.
- Blank phase: counter < BLANK_CYCLES. All anodes = 1.
- Drive phase: remaining cycles of the slot. Only anodes[idx] may be 0.
- anodes[idx] = 0 unless the digit is suppressed.

Outputs to the encoder:
- num = display[4*idx +: 4].
- dp = ~dp_mask[idx].
- Both are registered and change on the same edge as the index advance, i.e. during blank.
- Latency from index change to num/anodes update: 1 cycle.

Leading-zero suppression:
- Applies when LZ_SUPPRESS = 1, idx > 0, and every nibble at positions idx..NUM_DIGITS-1 is 0.
- A suppressed digit keeps anodes[idx] = 1 for the whole slot.
- Digit 0 is never suppressed; value 0 shows a single "0".
- A set dp_mask bit overrides suppression for that digit.

Update handshake:
- Transfer occurs when value_valid && value_ready.
- value_ready = pending empty.
- A transferred value goes to pending.
- The display register changes only at the commit edge, to prevent tearing. The commit edge is the wrap from idx = NUM_DIGITS-1, counter = REFRESH_DIV-1.
- frame_done is 1 in the cycle after the commit edge.

Commit edge rules:
- Pending full: display <= pending. Pending empties, so value_ready returns to 1 next cycle.
- Pending empty and a transfer occurs on this edge: display <= value directly (bypass); pending stays empty.
- Otherwise: display unchanged.

Other boundary cases:
- value_valid held while ready = 0: stalls; value is not dropped.
- Reset mid-frame: all state returns immediately to reset values. Any pending value is discarded.
- dp_mask changes take effect at the next slot's output register update.

Decomposition:
- Package skylark_display_pkg holds:
  - NUM_DIGITS_DEF = 8.
  - typedef digit_idx_t (logic [2:0]).
  - typedef nibble_t (logic [3:0]).
  - ANODES_OFF constant (all ones).
- One sub-module, refresh_timer, wraps the slot counter. Parameters REFRESH_DIV and BLANK_CYCLES; outputs slot_tick (wrap pulse) and blank (phase flag).
- Index, suppression logic, handshake and output registers stay in display_scanner.

Test Plan (REFRESH_DIV = 4, BLANK_CYCLES = 1, NUM_DIGITS = 8, LZ_SUPPRESS = 1):
- Reset scan: after reset release, idle with value = 0 -> only digit 0 is driven: anodes = 8'hFE for 3 of every 4 cycles, 8'hFF otherwise. num = 0. frame_done period = 32 cycles.
- Full value: load 32'h1234ABCD, wait for frame_done -> slot k shows num = nibble k (D, C, B, A, 4, 3, 2, 1) with anodes = ~(1 << k) in drive phase, all 1 in blank phase.
- Leading zero and dp: load 32'h00000F00 with dp_mask = 8'h10 -> digits 0-2 and digit 4 light; digits 3 and 5-7 stay off. dp = 0 only in slot 4.
- Tearing and backpressure: load A mid-frame, then offer B -> B stalls with value_ready = 0. A appears only after the commit edge. B is accepted in the cycle after the commit edge and displays one frame later.
- Commit bypass: pending empty, transfer 32'h5 exactly on the commit edge -> display = 5 on the next frame. value_ready stays 1 throughout.
- Async reset: assert reset mid-slot (idx = 5, pending full) -> anodes = 8'hFF and value_ready = 1 without waiting for a clock edge. After release the scan restarts at idx 0 showing 0.
